bram_stream_reader: RTL and testbench

Read-side sequencer for the single-port `bram` used in the convolution datapath. On a start command it walks a contiguous (or strided) address range of one BRAM instance and turns the one-cycle-latency read port into a valid/ready stream with full backpressure support. It sits between each weight/feature BRAM and the convolution engine's input stage.

---
 rtl/conv_pkg.sv | 13 +
 rtl/stream_skid_fifo.sv | 46 ++++
 rtl/bram_stream_reader.sv | 153 +++++++++++++++
 tb/tb_bram_stream_reader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution datapath BRAM stream readers.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } reader_state_t;

  localparam int READER_FIFO_DEPTH = 2;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO that absorbs BRAM read data while the stream consumer stalls.
module stream_skid_fifo
  import conv_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [READER_FIFO_DEPTH];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_count;

  // Entries are cleared on reset so the head reads as zero when empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (i_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/bram_stream_reader.sv
// Walks an address range of one BRAM and presents the read data as a valid/ready stream.
// Optional BRAM_READER_STRIDE_EN adds a 'stride' input; otherwise addresses step by one.
module bram_stream_reader
  import conv_pkg::*;
#(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [RAM_ADDR_BITS-1:0]    base_address,
  input  logic [RAM_ADDR_BITS:0]      length,
`ifdef BRAM_READER_STRIDE_EN
  input  logic [RAM_ADDR_BITS-1:0]    stride,
`endif
  output logic                        busy,
  output logic                        done,
  output logic                        ram_enable,
  output logic                        write_enable,
  output logic [RAM_ADDR_BITS-1:0]    address,
  input  logic signed [RAM_WIDTH-1:0] ram_data,
  output logic signed [RAM_WIDTH-1:0] m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last
);

  localparam logic [RAM_ADDR_BITS:0]   LEN_ONE  = 1;
  localparam logic [RAM_ADDR_BITS:0]   LEN_ZERO = 0;
  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = 1;

  reader_state_t              r_state;
  logic [RAM_ADDR_BITS-1:0]   r_addr;
  logic [RAM_ADDR_BITS:0]     r_length;
  logic [RAM_ADDR_BITS:0]     r_issued;
  logic                       r_pending;
  logic                       r_pendingLast;
  logic                       r_busy;
  logic                       r_done;

  logic [RAM_ADDR_BITS-1:0]   w_step;
  logic [RAM_WIDTH:0]         w_head;
  logic                       w_headLast;
  logic                       w_valid;
  logic [1:0]                 w_count;
  logic                       w_pop;
  logic                       w_credit;
  logic                       w_issue;
  logic                       w_issueLast;

`ifdef BRAM_READER_STRIDE_EN
  logic [RAM_ADDR_BITS-1:0]   r_stride;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stride <= '0;
    end else if (r_state == IDLE && start) begin
      r_stride <= stride;
    end
  end

  assign w_step = r_stride;
`else
  assign w_step = ADDR_ONE;
`endif

  // Credit counts the buffered words plus the one still inside the BRAM, net of
  // this cycle's pop, so a new issue can never land in a full buffer.
  assign w_pop       = w_valid & m_ready;
  assign w_credit    = (({1'b0, w_count} + {2'b00, r_pending}) - {2'b00, w_pop}) < 3'd2;
  assign w_issue     = (r_state == READ) && (r_issued != r_length) && w_credit;
  assign w_issueLast = ((r_issued + LEN_ONE) == r_length);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_length      <= '0;
      r_issued      <= '0;
      r_pending     <= 1'b0;
      r_pendingLast <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_pending     <= w_issue;
      r_pendingLast <= w_issue & w_issueLast;
      r_done        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr   <= base_address;
            r_length <= length;
            r_issued <= '0;
            if (length == LEN_ZERO) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= READ;
              r_busy  <= 1'b1;
            end
          end
        end
        READ: begin
          if (w_issue) begin
            r_addr   <= r_addr + w_step;
            r_issued <= r_issued + LEN_ONE;
            if (w_issueLast) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_pop && w_headLast) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  stream_skid_fifo #(
    .WIDTH (RAM_WIDTH + 1)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (r_pending),
    .i_data  ({r_pendingLast, ram_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  assign w_headLast   = w_head[RAM_WIDTH];
  assign m_data       = w_head[RAM_WIDTH-1:0];
  assign m_valid      = w_valid;
  assign m_last       = w_valid & w_headLast;
  assign ram_enable   = w_issue;
  assign address      = r_addr;
  assign write_enable = 1'b0;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: a word-level stream model plus literal spot checks.
module tb_bram_stream_reader;

  localparam int W     = 32;
  localparam int AB    = 9;
  localparam int DEPTH = 512;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [AB-1:0]       base_address = '0;
  logic [AB:0]         length = '0;
`ifdef BRAM_READER_STRIDE_EN
  logic [AB-1:0]       stride = '0;
`endif
  logic                busy;
  logic                done;
  logic                ram_enable;
  logic                write_enable;
  logic [AB-1:0]       address;
  logic signed [W-1:0] ram_data;
  logic signed [W-1:0] m_data;
  logic                m_valid;
  logic                m_ready = 1'b1;
  logic                m_last;

  bram_stream_reader #(
    .RAM_WIDTH     (W),
    .RAM_ADDR_BITS (AB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .base_address (base_address),
    .length       (length),
`ifdef BRAM_READER_STRIDE_EN
    .stride       (stride),
`endif
    .busy         (busy),
    .done         (done),
    .ram_enable   (ram_enable),
    .write_enable (write_enable),
    .address      (address),
    .ram_data     (ram_data),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last)
  );

  always #5 clock = ~clock;

  // Behavioural single-port BRAM with one cycle of read latency.
  logic signed [W-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_enable) ram_data <= mem[address];
  end

  int nChecks = 0;
  int nFails  = 0;

  // Model: expected word stream, expected issue addresses, and occupancy counts.
  int expData [$];
  bit expLast [$];
  int expAddr [$];
  int toIssue    = 0;
  int buffered   = 0;
  bit issuedPrev = 1'b0;
  bit expBusy    = 1'b0;
  bit expDone    = 1'b0;
  bit modelOn    = 1'b0;
  int nPopped    = 0;
  int lastWord   = -1;
  bit readyPattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Every cycle the transfer model is live, outputs are compared against it.
  always @(negedge clock) begin : compare
    bit expValid;
    bit pop;
    bit expEnable;
    if (!reset && modelOn) begin
      expValid  = (buffered > 0);
      pop       = expValid && (m_ready == 1'b1);
      expEnable = (toIssue > 0) && ((buffered + int'(issuedPrev) - int'(pop)) < 2);
      checkOutput("write_enable", write_enable, 0);
      checkOutput("busy", busy, expBusy);
      checkOutput("done", done, expDone);
      checkOutput("ram_enable", ram_enable, expEnable);
      checkOutput("m_valid", m_valid, expValid);
      if (ram_enable === 1'b1 && expAddr.size() > 0) begin
        checkOutput("address", address, expAddr.pop_front());
      end
      if (expValid && expData.size() > 0) begin
        checkOutput("m_data", m_data, expData[0]);
        checkOutput("m_last", m_last, expLast[0]);
      end
      expDone = 1'b0;
      if (pop && expData.size() > 0) begin
        lastWord = expData[0];
        nPopped++;
        if (expLast[0]) begin
          expDone = 1'b1;
          expBusy = 1'b0;
        end
        void'(expData.pop_front());
        void'(expLast.pop_front());
      end
      buffered   = buffered + int'(issuedPrev) - int'(pop);
      issuedPrev = expEnable;
      if (expEnable) toIssue--;
    end
  end

  // Called just after a rising edge; returns just after the edge that samples start.
  task automatic applyStimulus(input int base, input int len, input int str);
    int a;
    start        = 1'b1;
    base_address = base[AB-1:0];
    length       = len[AB:0];
`ifdef BRAM_READER_STRIDE_EN
    stride       = str[AB-1:0];
`endif
    for (int i = 0; i < len; i++) begin
      a = (base + i * str) % DEPTH;
      expAddr.push_back(a);
      expData.push_back(int'(mem[a]));
      expLast.push_back(i == len - 1);
    end
    @(posedge clock);
    #1;
    start   = 1'b0;
    toIssue = len;
    expBusy = (len > 0);
    expDone = (len == 0);
    nPopped = 0;
    modelOn = 1'b1;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    modelOn = 1'b0;
    expData.delete();
    expLast.delete();
    expAddr.delete();
    toIssue    = 0;
    buffered   = 0;
    issuedPrev = 1'b0;
    expBusy    = 1'b0;
    expDone    = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ram_enable", ram_enable, 0);
    checkOutput("rst_write_enable", write_enable, 0);
    checkOutput("rst_address", address, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_last", m_last, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic waitDone(input string name, input bit toggle);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (toggle) m_ready = readyPattern[k % 4];
      @(negedge clock);
      seen = (done === 1'b1);
      @(posedge clock);
      #1;
    end
    m_ready = 1'b1;
    checkOutput({name, "_finished"}, seen, 1);
    checkOutput({name, "_drained"}, expData.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = i;

    doReset();

    // Base 0, length 4, consumer always ready: literal cycle-by-cycle expectations.
    applyStimulus(0, 4, 1);
    @(negedge clock);
    checkOutput("t1_c1_ram_enable", ram_enable, 1);
    checkOutput("t1_c1_address", address, 0);
    checkOutput("t1_c1_busy", busy, 1);
    @(negedge clock);
    checkOutput("t1_c2_address", address, 1);
    checkOutput("t1_c2_m_valid", m_valid, 0);
    @(negedge clock);
    checkOutput("t1_c3_m_valid", m_valid, 1);
    checkOutput("t1_c3_m_data", m_data, 0);
    @(negedge clock);
    checkOutput("t1_c4_m_data", m_data, 1);
    @(negedge clock);
    checkOutput("t1_c5_m_data", m_data, 2);
    checkOutput("t1_c5_m_last", m_last, 0);
    checkOutput("t1_c5_ram_enable", ram_enable, 0);
    @(negedge clock);
    checkOutput("t1_c6_m_data", m_data, 3);
    checkOutput("t1_c6_m_last", m_last, 1);
    @(negedge clock);
    checkOutput("t1_c7_done", done, 1);
    checkOutput("t1_c7_busy", busy, 0);
    @(posedge clock);
    #1;

    // Address wrap from the top of the BRAM.
    applyStimulus(510, 4, 1);
    waitDone("t2", 1'b0);
    checkOutput("t2_last_word", lastWord, 1);

    // Backpressure with ready toggling 1,0,0,1.
    applyStimulus(20, 8, 1);
    waitDone("t3", 1'b1);
    checkOutput("t3_last_word", lastWord, 27);

    // Zero-length transfer.
    applyStimulus(5, 0, 1);
    @(negedge clock);
    checkOutput("t4_done", done, 1);
    checkOutput("t4_ram_enable", ram_enable, 0);
    checkOutput("t4_m_valid", m_valid, 0);
    checkOutput("t4_busy", busy, 0);
    @(negedge clock);
    checkOutput("t4_done_pulse", done, 0);
    @(posedge clock);
    #1;

    // Reset after three words, then a fresh transfer.
    applyStimulus(0, 8, 1);
    for (int k = 0; k < 50 && nPopped < 3; k++) begin
      @(posedge clock);
      #1;
    end
    checkOutput("t5_words_before_reset", nPopped, 3);
    doReset();
    applyStimulus(100, 2, 1);
    waitDone("t5", 1'b0);
    checkOutput("t5_last_word", lastWord, 101);

`ifdef BRAM_READER_STRIDE_EN
    // Strided walk: addresses 0,3,6,9.
    applyStimulus(0, 4, 3);
    waitDone("t6", 1'b0);
    checkOutput("t6_last_word", lastWord, 9);
`endif

    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
